hamming_frame_ctrl: RTL and testbench
=====================================

HAMMING_FRAME_CTRL -- requirements
Module: hamming_frame_ctrl

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 16, giving payload bytes per frame (1..255).
REQ-002 The block SHALL have parameter BIT_DIV, default 100, giving clk cycles per transmitted bit (>=2).
REQ-003 The block SHALL have parameter SYNC_WORD, default 12'hE25, giving the 12-bit sync word sent before the payload.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle frame request, honoured only in IDLE.
REQ-007 The block SHALL have ports s_data, input, 8 bits; s_valid, input, 1 bit; s_ready, output, 1 bit: the payload byte stream.
REQ-008 The block SHALL have ports tx_bit, output, 1 bit: serial line data; tx_en, output, 1 bit: line active.
REQ-009 The block SHALL have port tx_bit_stb, output, 1 bit: one-cycle pulse on the first cycle of each bit.
REQ-010 The block SHALL have ports busy, output, 1 bit; done, output, 1 bit (one-cycle pulse); underrun, output, 1 bit (one-cycle pulse).

Function
REQ-011 States SHALL be IDLE, SYNC, SHIFT and DONE.
REQ-012 IDLE with start=1 SHALL move to SYNC, load the shift register with SYNC_WORD, clear the counters and set busy=1.
REQ-013 In SYNC and SHIFT, tx_en SHALL be 1, tx_bit SHALL be shift-register bit 11 (MSB first), and bits SHALL advance every BIT_DIV cycles.
REQ-014 tx_bit_stb SHALL pulse when the divider counter equals 0, including the first cycle after entering SYNC.
REQ-015 Prefetch: s_ready SHALL be 1 in SYNC/SHIFT only while the next-codeword buffer is empty, no encode is in flight, and bytes fetched < FRAME_LEN.
REQ-016 A transfer (s_valid & s_ready) SHALL drive the encoder's wren=1, data=s_data for that cycle only; the encoder output SHALL be captured into the next-codeword buffer on its encode_valid one cycle later.
REQ-017 Codeword format SHALL be {d7,d6,d5,d4,p3,d3,d2,d1,p2,d0,p1,p0} with p0=d6^d4^d3^d1^d0, p1=d6^d5^d3^d2^d0, p2=d7^d3^d2^d1, p3=d7^d6^d5^d4.
REQ-018 On the last cycle of bit 11 of any word: if the bytes sent equal FRAME_LEN, the block SHALL go to DONE; if a buffered codeword exists, it SHALL load that codeword and stay in or enter SHIFT; otherwise it SHALL raise an underrun.
REQ-019 If encode_valid coincides with the word-boundary load, the block SHALL load hc_out directly into the shift register and SHALL leave the buffer empty.
REQ-020 On underrun, the block SHALL pulse underrun for one cycle, drop tx_en the next cycle, discard the rest of the frame and return to IDLE with no done pulse.
REQ-021 DONE SHALL last one cycle with done=1, tx_en=0 and busy=0 on exit, then go to IDLE.
REQ-022 start asserted while busy=1 SHALL be ignored.
REQ-023 Frame length SHALL be (FRAME_LEN+1)*12*BIT_DIV cycles with no gaps between bits.
REQ-024 Bytes-fetched and bytes-sent counters SHALL be 8 bits wide, and the bit index SHALL wrap 11 to 0.

Reset
REQ-025 While rst=1 at a clock edge, the block SHALL enter IDLE and set s_ready, tx_bit, tx_en, tx_bit_stb, busy, done and underrun to 0.
REQ-026 rst mid-frame SHALL abort immediately, with no done or underrun pulse, and SHALL clear the buffer and counters.
REQ-027 The first cycle after reset release SHALL accept start.

Structure
REQ-028 A shared package SHALL hold the state enum, the codeword width constant (12) and the default SYNC_WORD.
REQ-029 The block SHALL instantiate one sub-module, hamming_encoder (clk, rst, wren, data[7:0], hc_out[11:0], encode_valid, 1-cycle registered latency); it SHALL contain no other sub-modules.

Verification
REQ-030 With FRAME_LEN=2, BIT_DIV=4 and bytes 0x00, 0xFF always valid, start SHALL produce the serial sequence 0xE25, 0x000, 0xF77 over 144 cycles, then done for one cycle.
REQ-031 A single byte 0xA5 with FRAME_LEN=1 SHALL produce the payload codeword 0xA27 MSB first, with 12 tx_bit_stb pulses after the sync word.
REQ-032 With s_valid held low after the first byte (FRAME_LEN=2), underrun SHALL pulse at the end of word 2 (cycle 96), followed by tx_en=0, IDLE and no done.
REQ-033 start pulsed mid-frame SHALL have no effect, and rst asserted at cycle 50 SHALL make all outputs 0 on the next edge, with a new frame starting cleanly afterwards.
REQ-034 With s_valid asserted exactly on the last cycle of bit 11, the coincident-load case SHALL give the correct codeword with no gap and no underrun.

Source files
------------

// File: rtl/hamming_frame_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hamming_frame_ctrl_pkg
// Shared definitions for the Hamming-coded serial frame controller:
//   - frame FSM state encoding
//   - codeword width (12 bits: 8 data + 4 parity) and default sync word
//   - the (12,8) Hamming encode function used by hamming_encoder
// -----------------------------------------------------------------------------
package hamming_frame_ctrl_pkg;

    localparam int CW_WIDTH = 12;
    localparam int BYTE_WIDTH = 8;

    localparam logic [CW_WIDTH-1:0] DEFAULT_SYNC_WORD = 12'hE25;

    // Index of the last (LSB) bit of a codeword; bits go out 0..11, MSB first.
    localparam logic [3:0] LAST_BIT_IDX = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Codeword layout {d7,d6,d5,d4,p3,d3,d2,d1,p2,d0,p1,p0}: parity bits sit
    // at the power-of-two positions of a classic Hamming(12,8) code.
    function automatic logic [CW_WIDTH-1:0] hamming_encode(input logic [BYTE_WIDTH-1:0] d);
        logic p0, p1, p2, p3;
        p0 = d[6] ^ d[4] ^ d[3] ^ d[1] ^ d[0];
        p1 = d[6] ^ d[5] ^ d[3] ^ d[2] ^ d[0];
        p2 = d[7] ^ d[3] ^ d[2] ^ d[1];
        p3 = d[7] ^ d[6] ^ d[5] ^ d[4];
        return {d[7], d[6], d[5], d[4], p3, d[3], d[2], d[1], p2, d[0], p1, p0};
    endfunction

endpackage

// File: rtl/hamming_frame_ctrl_encoder.sv
// -----------------------------------------------------------------------------
// hamming_encoder
// Registered Hamming(12,8) encoder with one cycle of latency.
// Ports:
//   clk          - clock
//   rst          - synchronous active-high reset
//   wren         - encode request; data is sampled on this cycle
//   data[7:0]    - payload byte
//   hc_out[11:0] - codeword, valid while encode_valid is high
//   encode_valid - one-cycle pulse, the cycle after wren
// -----------------------------------------------------------------------------
module hamming_encoder
    import hamming_frame_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wren,
    input  logic [BYTE_WIDTH-1:0] data,
    output logic [CW_WIDTH-1:0]   hc_out,
    output logic                  encode_valid
);

    logic [CW_WIDTH-1:0] r_hc_out;
    logic                r_encode_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hc_out       <= '0;
            r_encode_valid <= 1'b0;
        end else begin
            r_encode_valid <= wren;
            if (wren) begin
                r_hc_out <= hamming_encode(data);
            end
        end
    end

    assign hc_out       = r_hc_out;
    assign encode_valid = r_encode_valid;

endmodule

// File: rtl/hamming_frame_ctrl.sv
// -----------------------------------------------------------------------------
// hamming_frame_ctrl
// Sends a frame on a serial line: a 12-bit sync word followed by FRAME_LEN
// Hamming(12,8) codewords, MSB first, each bit held for BIT_DIV clocks.
// Payload bytes are prefetched one codeword ahead from a valid/ready stream.
// Parameters:
//   FRAME_LEN  - payload bytes per frame (1..255)
//   BIT_DIV    - clocks per transmitted bit (>= 2)
//   SYNC_WORD  - 12-bit sync word sent before the payload
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   start      - one-cycle frame request, honoured only when idle
//   s_data, s_valid, s_ready - payload byte stream
//   tx_bit     - serial data, tx_en - line active
//   tx_bit_stb - pulse on the first clock of each bit
//   busy       - frame in progress
//   done       - one-cycle pulse after the last bit of a complete frame
//   underrun   - one-cycle pulse when the next codeword was not ready
// -----------------------------------------------------------------------------
module hamming_frame_ctrl
    import hamming_frame_ctrl_pkg::*;
#(
    parameter int                  FRAME_LEN = 16,
    parameter int                  BIT_DIV   = 100,
    parameter logic [CW_WIDTH-1:0] SYNC_WORD = DEFAULT_SYNC_WORD
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BYTE_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  tx_bit,
    output logic                  tx_en,
    output logic                  tx_bit_stb,
    output logic                  busy,
    output logic                  done,
    output logic                  underrun
);

    localparam int                DIV_W    = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [7:0]        LEN_B    = 8'(FRAME_LEN);

    state_t              r_state;
    logic [CW_WIDTH-1:0] r_shift;
    logic [DIV_W-1:0]    r_div;
    logic [3:0]          r_bit_idx;
    logic [7:0]          r_fetched;     // bytes accepted from the stream
    logic [7:0]          r_sent;        // payload codewords loaded for sending
    logic [CW_WIDTH-1:0] r_buf;         // next-codeword buffer
    logic                r_buf_valid;
    logic                r_underrun;

    logic                w_active;
    logic                w_bit_end;
    logic                w_word_end;
    logic                w_s_ready;
    logic                w_xfer;
    logic                w_encode_valid;
    logic [CW_WIDTH-1:0] w_hc_out;

    assign w_active   = (r_state == ST_SYNC) || (r_state == ST_SHIFT);
    assign w_bit_end  = w_active && (r_div == DIV_LAST);
    assign w_word_end = w_bit_end && (r_bit_idx == LAST_BIT_IDX);

    // Only one byte may be between the stream and the shift register: either
    // in the encoder pipeline or in the buffer. This keeps the buffer to a
    // single entry and makes a buffer/encoder collision impossible.
    assign w_s_ready = w_active && !r_buf_valid && !w_encode_valid && (r_fetched < LEN_B);
    assign w_xfer    = s_valid && w_s_ready;

    hamming_encoder u_encoder (
        .clk          (clk),
        .rst          (rst),
        .wren         (w_xfer),
        .data         (s_data),
        .hc_out       (w_hc_out),
        .encode_valid (w_encode_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_div       <= '0;
            r_bit_idx   <= '0;
            r_fetched   <= '0;
            r_sent      <= '0;
            r_buf       <= '0;
            r_buf_valid <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_underrun <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_SYNC;
                        r_shift     <= SYNC_WORD;
                        r_div       <= '0;
                        r_bit_idx   <= '0;
                        r_fetched   <= '0;
                        r_sent      <= '0;
                        r_buf_valid <= 1'b0;
                    end
                end

                ST_SYNC, ST_SHIFT: begin
                    if (w_xfer) begin
                        r_fetched <= r_fetched + 8'd1;
                    end

                    if (w_bit_end) begin
                        r_div <= '0;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end

                    if (w_bit_end && !w_word_end) begin
                        r_bit_idx <= r_bit_idx + 4'd1;
                        r_shift   <= {r_shift[CW_WIDTH-2:0], 1'b0};
                    end

                    if (w_encode_valid) begin
                        r_buf       <= w_hc_out;
                        r_buf_valid <= 1'b1;
                    end

                    // NOTE: these word-boundary assignments come after the
                    // buffer capture on purpose; the last non-blocking write
                    // wins, so a coincident encode goes straight to the shift
                    // register and the buffer stays empty.
                    if (w_word_end) begin
                        r_bit_idx <= '0;
                        if (r_sent == LEN_B) begin
                            r_state <= ST_DONE;
                        end else if (r_buf_valid) begin
                            r_shift     <= r_buf;
                            r_buf_valid <= 1'b0;
                            r_sent      <= r_sent + 8'd1;
                            r_state     <= ST_SHIFT;
                        end else if (w_encode_valid) begin
                            r_shift     <= w_hc_out;
                            r_buf_valid <= 1'b0;
                            r_sent      <= r_sent + 8'd1;
                            r_state     <= ST_SHIFT;
                        end else begin
                            // Nothing to send next: abandon the frame.
                            r_underrun <= 1'b1;
                            r_state    <= ST_IDLE;
                        end
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // All outputs decode registered state, so reset forces them low directly.
    assign tx_en      = w_active;
    assign tx_bit     = w_active && r_shift[CW_WIDTH-1];
    assign tx_bit_stb = w_active && (r_div == '0);
    assign s_ready    = w_s_ready;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_hamming_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hamming_frame_ctrl
// Two instances share clk/rst: u_dut0 (FRAME_LEN=2) and u_dut1 (FRAME_LEN=1),
// both BIT_DIV=4. Expected codewords are queued when the sync word is
// requested and when each byte is handed over; a receiver rebuilds words from
// tx_bit at each tx_bit_stb and compares them against the queue heads.
// All activity runs in one process: outputs are sampled on the falling edge,
// inputs are driven 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_hamming_frame_ctrl;

    localparam int          BD   = 4;
    localparam logic [11:0] SYNC = 12'hE25;

    logic clk;
    logic rst;

    logic       start0, s_valid0, s_ready0, tx_bit0, tx_en0, tx_bit_stb0, busy0, done0, underrun0;
    logic [7:0] s_data0;
    logic       start1, s_valid1, s_ready1, tx_bit1, tx_en1, tx_bit_stb1, busy1, done1, underrun1;
    logic [7:0] s_data1;

    hamming_frame_ctrl #(.FRAME_LEN(2), .BIT_DIV(BD), .SYNC_WORD(SYNC)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .s_data(s_data0), .s_valid(s_valid0), .s_ready(s_ready0),
        .tx_bit(tx_bit0), .tx_en(tx_en0), .tx_bit_stb(tx_bit_stb0),
        .busy(busy0), .done(done0), .underrun(underrun0)
    );

    hamming_frame_ctrl #(.FRAME_LEN(1), .BIT_DIV(BD), .SYNC_WORD(SYNC)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
        .tx_bit(tx_bit1), .tx_en(tx_en1), .tx_bit_stb(tx_bit_stb1),
        .busy(busy1), .done(done1), .underrun(underrun1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference Hamming(12,8) encoder written directly from the codeword layout.
    function automatic logic [11:0] ref_code(input logic [7:0] d);
        logic p0, p1, p2, p3;
        p0 = d[6] ^ d[4] ^ d[3] ^ d[1] ^ d[0];
        p1 = d[6] ^ d[5] ^ d[3] ^ d[2] ^ d[0];
        p2 = d[7] ^ d[3] ^ d[2] ^ d[1];
        p3 = d[7] ^ d[6] ^ d[5] ^ d[4];
        return {d[7], d[6], d[5], d[4], p3, d[3], d[2], d[1], p2, d[0], p1, p0};
    endfunction

    // Stream sources and scoreboards.
    logic [7:0]  src0[$], src1[$];
    logic [11:0] exp0[$], exp1[$];
    logic        xf0, xf1;

    // Receiver state and activity counters.
    logic [11:0] asm0, asm1, last_word1;
    int          nb0, nb1;
    int          en_cnt0, stb_cnt0, done_cnt0, und_cnt0;
    int          en_cnt1, stb_cnt1, done_cnt1, und_cnt1;

    int cyc = 0;
    int t0  = 0;
    int k;

    task automatic refresh();
        s_valid0 = (src0.size() > 0);
        s_data0  = (src0.size() > 0) ? src0[0] : 8'h00;
        s_valid1 = (src1.size() > 0);
        s_data1  = (src1.size() > 0) ? src1[0] : 8'h00;
    endtask

    task automatic clr_counts();
        en_cnt0 = 0; stb_cnt0 = 0; done_cnt0 = 0; und_cnt0 = 0;
        en_cnt1 = 0; stb_cnt1 = 0; done_cnt1 = 0; und_cnt1 = 0;
    endtask

    // Falling edge: observe both DUTs and note handshakes for the coming edge.
    task automatic half_neg();
        @(negedge clk);
        if (rst) begin
            asm0 = '0; nb0 = 0;
            asm1 = '0; nb1 = 0;
        end else begin
            if (tx_en0)    en_cnt0++;
            if (done0)     done_cnt0++;
            if (underrun0) und_cnt0++;
            if (tx_bit_stb0) begin
                stb_cnt0++;
                asm0 = {asm0[10:0], tx_bit0};
                nb0++;
                if (nb0 == 12) begin
                    nb0 = 0;
                    if (exp0.size() == 0) check("word0_unexpected", 32'(asm0), 32'hFFFF_FFFF);
                    else                  check("word0", 32'(asm0), 32'(exp0.pop_front()));
                end
            end
            if (tx_en1)    en_cnt1++;
            if (done1)     done_cnt1++;
            if (underrun1) und_cnt1++;
            if (tx_bit_stb1) begin
                stb_cnt1++;
                asm1 = {asm1[10:0], tx_bit1};
                nb1++;
                if (nb1 == 12) begin
                    nb1 = 0;
                    last_word1 = asm1;
                    if (exp1.size() == 0) check("word1_unexpected", 32'(asm1), 32'hFFFF_FFFF);
                    else                  check("word1", 32'(asm1), 32'(exp1.pop_front()));
                end
            end
        end
        xf0 = s_valid0 && s_ready0 && !rst;
        xf1 = s_valid1 && s_ready1 && !rst;
    endtask

    // Rising edge + 1: retire accepted bytes into the scoreboards.
    task automatic half_pos();
        @(posedge clk);
        #1;
        cyc++;
        if (xf0) exp0.push_back(ref_code(src0.pop_front()));
        if (xf1) exp1.push_back(ref_code(src1.pop_front()));
        refresh();
    endtask

    task automatic tick();
        half_neg();
        half_pos();
    endtask

    // Advance to the drive point of frame cycle c (cycle 0 = first SYNC cycle).
    task automatic goto_cycle(input int c);
        while (cyc - t0 < c) tick();
    endtask

    task automatic start_frame(input int which);
        if (which == 0) begin start0 = 1'b1; exp0.push_back(SYNC); end
        else            begin start1 = 1'b1; exp1.push_back(SYNC); end
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
        t0 = cyc;
    endtask

    // Returns at the falling edge of the event cycle; k is its frame cycle
    // index, or the budget if the event never came.
    task automatic wait_evt(input int which, input bit want_done, input int budget, output int kk);
        logic ev;
        kk = 0;
        while (1'b1) begin
            half_neg();
            kk = cyc - t0;
            if (which == 0) ev = want_done ? done0 : underrun0;
            else            ev = done1;
            if (ev === 1'b1 || kk >= budget) break;
            half_pos();
        end
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        asm0 = '0; asm1 = '0; last_word1 = '0; nb0 = 0; nb1 = 0;
        xf0 = 1'b0; xf1 = 1'b0;
        clr_counts();
        refresh();

        // ---- reset state --------------------------------------------------
        repeat (3) tick();
        half_neg();
        check("rst_s_ready",    32'(s_ready0),    32'd0);
        check("rst_tx_bit",     32'(tx_bit0),     32'd0);
        check("rst_tx_en",      32'(tx_en0),      32'd0);
        check("rst_tx_bit_stb", 32'(tx_bit_stb0), 32'd0);
        check("rst_busy",       32'(busy0),       32'd0);
        check("rst_done",       32'(done0),       32'd0);
        check("rst_underrun",   32'(underrun0),   32'd0);
        half_pos();

        // ---- bytes 0x00, 0xFF; start on the first cycle after reset release
        rst = 1'b0;
        src0.push_back(8'h00);
        src0.push_back(8'hFF);
        refresh();
        clr_counts();
        start_frame(0);
        half_neg();
        check("sync_first_tx_en",  32'(tx_en0),      32'd1);
        check("sync_first_stb",    32'(tx_bit_stb0), 32'd1);
        check("sync_first_busy",   32'(busy0),       32'd1);
        check("sync_first_bit",    32'(tx_bit0),     32'd1);
        check("sync_first_ready",  32'(s_ready0),    32'd1);
        half_pos();
        goto_cycle(30);
        start0 = 1'b1;                  // ignored: frame already running
        tick();
        start0 = 1'b0;
        wait_evt(0, 1'b1, 400, k);
        check("f1_done_cycle",   32'(k),      32'd144);
        check("f1_done_tx_en",   32'(tx_en0), 32'd0);
        half_pos();
        half_neg();
        check("f1_done_width",   32'(done0),  32'd0);
        check("f1_busy_after",   32'(busy0),  32'd0);
        half_pos();
        tick();
        check("f1_tx_en_cycles", 32'(en_cnt0),     32'd144);
        check("f1_stb_count",    32'(stb_cnt0),    32'd36);
        check("f1_done_count",   32'(done_cnt0),   32'd1);
        check("f1_underruns",    32'(und_cnt0),    32'd0);
        check("f1_words_left",   32'(exp0.size()), 32'd0);

        // ---- underrun: only one byte ever offered -------------------------
        clr_counts();
        src0.push_back(8'h3C);
        refresh();
        start_frame(0);
        wait_evt(0, 1'b0, 400, k);
        check("ur_cycle",        32'(k),      32'd96);
        check("ur_busy",         32'(busy0),  32'd0);
        half_pos();
        half_neg();
        check("ur_width",        32'(underrun0), 32'd0);
        check("ur_tx_en_next",   32'(tx_en0),    32'd0);
        half_pos();
        repeat (60) tick();
        check("ur_tx_en_cycles", 32'(en_cnt0),     32'd96);
        check("ur_no_done",      32'(done_cnt0),   32'd0);
        check("ur_count",        32'(und_cnt0),    32'd1);
        check("ur_words_left",   32'(exp0.size()), 32'd0);

        // ---- reset mid-frame, then a clean frame --------------------------
        clr_counts();
        src0.push_back(8'h12);
        src0.push_back(8'h34);
        refresh();
        start_frame(0);
        goto_cycle(50);
        rst = 1'b1;
        tick();
        half_neg();
        check("mrst_s_ready",    32'(s_ready0),    32'd0);
        check("mrst_tx_bit",     32'(tx_bit0),     32'd0);
        check("mrst_tx_en",      32'(tx_en0),      32'd0);
        check("mrst_tx_bit_stb", 32'(tx_bit_stb0), 32'd0);
        check("mrst_busy",       32'(busy0),       32'd0);
        check("mrst_done",       32'(done0),       32'd0);
        check("mrst_underrun",   32'(underrun0),   32'd0);
        half_pos();
        exp0.delete();
        src0.delete();
        refresh();
        rst = 1'b0;
        tick();
        check("mrst_no_done_pulse", 32'(done_cnt0), 32'd0);
        check("mrst_no_ur_pulse",   32'(und_cnt0),  32'd0);
        clr_counts();
        src0.push_back(8'h5A);
        src0.push_back(8'hC3);
        refresh();
        start_frame(0);
        wait_evt(0, 1'b1, 400, k);
        check("f2_done_cycle", 32'(k), 32'd144);
        half_pos();
        repeat (2) tick();
        check("f2_tx_en_cycles", 32'(en_cnt0),     32'd144);
        check("f2_underruns",    32'(und_cnt0),    32'd0);
        check("f2_words_left",   32'(exp0.size()), 32'd0);

        // ---- encode_valid lands exactly on each word's last cycle ----------
        // The byte is presented on the cycle before the boundary so its
        // one-cycle encode completes on the boundary cycle itself.
        clr_counts();
        start_frame(0);
        goto_cycle(46);
        src0.push_back(8'h81);
        refresh();
        goto_cycle(48);
        half_neg();
        check("co_buf_empty_ready", 32'(s_ready0), 32'd1);
        check("co_no_gap_tx_en",    32'(tx_en0),   32'd1);
        half_pos();
        goto_cycle(94);
        src0.push_back(8'h7E);
        refresh();
        wait_evt(0, 1'b1, 400, k);
        check("co_done_cycle", 32'(k), 32'd144);
        half_pos();
        repeat (2) tick();
        check("co_tx_en_cycles", 32'(en_cnt0),     32'd144);
        check("co_underruns",    32'(und_cnt0),    32'd0);
        check("co_words_left",   32'(exp0.size()), 32'd0);

        // ---- FRAME_LEN=1 instance, byte 0xA5 ------------------------------
        clr_counts();
        src1.push_back(8'hA5);
        refresh();
        start_frame(1);
        wait_evt(1, 1'b1, 300, k);
        check("one_done_cycle", 32'(k), 32'd96);
        half_pos();
        repeat (2) tick();
        check("one_payload_a5",   32'(last_word1),   32'hA27);
        check("one_stb_count",    32'(stb_cnt1),     32'd24);
        check("one_tx_en_cycles", 32'(en_cnt1),      32'd96);
        check("one_done_count",   32'(done_cnt1),    32'd1);
        check("one_underruns",    32'(und_cnt1),     32'd0);
        check("one_words_left",   32'(exp1.size()),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
